// File: rtl/result_drain_controller_if.sv
// result_drain_controller_if: valid/ready result stream from the drain FIFO head to the sink.
interface result_drain_controller_if #(
  parameter int RESULT_WIDTH = 16,
  parameter int COL_W = 5
);
  logic signed [RESULT_WIDTH-1:0] data;
  logic [COL_W-1:0] col;
  logic last;
  logic valid;
  logic ready;
  modport master (output data, col, last, valid, input ready);
  modport slave (input data, col, last, valid, output ready);
endinterface

// File: rtl/result_drain_controller.sv
// result_drain_controller: snapshots column results on capture and drains active columns through a FWFT FIFO.
// Optional RESULT_DRAIN_RELU_EN clamps negative results to zero on push.
module result_drain_controller #(
  parameter int N_COLS_ARRAY = 20,
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int COL_W = $clog2(N_COLS_ARRAY),
  localparam int NC_W = $clog2(N_COLS_ARRAY + 1)
) (
  input  logic clk_i,
  input  logic general_rst_i,
  input  logic capture_i,
  input  logic [N_COLS_ARRAY*RESULT_WIDTH-1:0] result_i,
  input  logic [NC_W-1:0] n_cols_i,
  result_drain_controller_if.master m,
  output logic busy_o,
  output logic overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int EW = RESULT_WIDTH + COL_W + 1;
  typedef enum logic {IDLE, DRAIN} state_e;
  state_e state_q, state_d;
  logic [N_COLS_ARRAY*RESULT_WIDTH-1:0] shadow_q, shadow_d;
  logic [NC_W-1:0] ncols_q, ncols_d;
  logic [COL_W-1:0] col_q, col_d;
  logic ovf_q, ovf_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [RESULT_WIDTH-1:0] sel, push_data;
  logic full, pop, push, is_last, fin, accept;
  assign sel = shadow_q[col_q*RESULT_WIDTH +: RESULT_WIDTH];
`ifdef RESULT_DRAIN_RELU_EN
  assign push_data = sel[RESULT_WIDTH-1] ? '0 : sel;
`else
  assign push_data = sel;
`endif
  assign full = cnt_q == CNT_W'(FIFO_DEPTH);
  assign m.valid = cnt_q != '0;
  assign pop = m.valid & m.ready;
  assign push = (state_q == DRAIN) && (!full || pop);
  assign is_last = NC_W'(col_q) == ncols_q - NC_W'(1);
  assign fin = push && is_last;
  // A capture landing on the final push starts the next round with no bubble
  assign accept = capture_i && (n_cols_i != '0) && (state_q == IDLE || fin);
  assign {m.data, m.col, m.last} = m.valid ? mem_q[rd_q] : '0;
  assign busy_o = state_q == DRAIN;
  assign overflow_o = ovf_q;
  always_comb begin
    state_d = fin ? IDLE : state_q;
    shadow_d = shadow_q;
    ncols_d = ncols_q;
    col_d = push ? col_q + COL_W'(1) : col_q;
    ovf_d = ovf_q | (capture_i && state_q == DRAIN && !fin);
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (accept) begin
      state_d = DRAIN;
      shadow_d = result_i;
      ncols_d = n_cols_i > NC_W'(N_COLS_ARRAY) ? NC_W'(N_COLS_ARRAY) : n_cols_i;
      col_d = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (general_rst_i) begin
      state_q <= IDLE;
      shadow_q <= '0;
      ncols_q <= '0;
      col_q <= '0;
      ovf_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      ncols_q <= ncols_d;
      col_q <= col_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {push_data, col_q, is_last};
  end
endmodule
